// File: rtl/mean_pkg.sv
// Shared constants and types for the mean_avg datapath and its window loader.
//   NUM_INPUTS : samples per window (mean_avg input count)
//   WID        : sample width in bits
//   IDX_WID    : width of a slot index within one window
//   state_e    : loader fill-control states
package mean_pkg;

    localparam int NUM_INPUTS = 128;
    localparam int WID        = 16;
    localparam int IDX_WID    = $clog2(NUM_INPUTS);

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        FULL_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/window_bank.sv
// Double buffer for one window: a fill buffer written one slot at a time and
// an output buffer that is loaded in one shot on publish.
//   clk, rst    : clock, asynchronous active-low reset
//   wr_en       : write wr_data into fill slot wr_slot
//   wr_slot     : fill-buffer slot index
//   wr_data     : sample value
//   pub_en      : copy the fill buffer into the output buffer; a sample being
//                 written on the same edge is forwarded into the copy
//   frame_data  : output buffer, sample i at [i*WID +: WID]
module window_bank #(
    parameter int NUM_INPUTS = 128,
    parameter int WID        = 16,
    parameter int IDX_WID    = $clog2(NUM_INPUTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [IDX_WID-1:0]         wr_slot,
    input  logic [WID-1:0]             wr_data,
    input  logic                       pub_en,
    output logic [NUM_INPUTS*WID-1:0]  frame_data
);
    import mean_pkg::*;

    logic [WID-1:0]            fill_r [NUM_INPUTS];
    logic [NUM_INPUTS*WID-1:0] out_r;

    // Fill-buffer slot writes and publish copy into the output buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                fill_r[i] <= '0;
            end
            out_r <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (wr_en && (wr_slot == IDX_WID'(i))) begin
                    fill_r[i] <= wr_data;
                end
                // The completing sample is not yet in fill_r, so forward it.
                if (pub_en) begin
                    out_r[i*WID +: WID] <= (wr_en && (wr_slot == IDX_WID'(i))) ? wr_data : fill_r[i];
                end
            end
        end
    end

    assign frame_data = out_r;

endmodule

// File: rtl/mean_window_loader.sv
// Collects a serial valid/ready sample stream into NUM_INPUTS-sample windows
// and presents each complete window as a flat, stable bus for mean_avg.
// The next window fills while the previous one is held; upstream stalls only
// when both buffers are occupied.
//   clk, rst           : clock, asynchronous active-low reset
//   in_valid/in_ready  : sample handshake, in_data sample, in_sof = slot 0 resync
//   frame_valid/ready  : window handshake, frame_data window bus
//   frame_cnt          : windows published, wraps
//   sof_err            : one-cycle pulse when in_sof discards a partial window
module mean_window_loader #(
    parameter int NUM_INPUTS = mean_pkg::NUM_INPUTS,
    parameter int WID        = mean_pkg::WID,
    parameter int CNT_WID    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WID-1:0]             in_data,
    input  logic                       in_sof,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [NUM_INPUTS*WID-1:0]  frame_data,
    output logic [CNT_WID-1:0]         frame_cnt,
    output logic                       sof_err
);
    import mean_pkg::*;

    localparam int                 IDX_WID      = $clog2(NUM_INPUTS);
    localparam logic [IDX_WID-1:0] LAST_IDX     = IDX_WID'(NUM_INPUTS - 1);
    localparam logic [0:0]         ST_FILL      = FILL;
    localparam logic [0:0]         ST_FULL_WAIT = FULL_WAIT;

    logic [0:0]         state_r;
    logic [IDX_WID-1:0] wr_idx_r;
    logic               frame_valid_r;
    logic [CNT_WID-1:0] frame_cnt_r;
    logic               sof_err_r;
    logic               in_ready_r;

    logic               accept_s;
    logic [IDX_WID-1:0] slot_s;
    logic               complete_s;
    logic               pub_ok_s;
    logic               publish_s;
    logic [0:0]         state_nx_s;
    logic [IDX_WID-1:0] wr_idx_nx_s;
    logic               frame_valid_nx_s;

    assign accept_s   = in_valid & in_ready_r;
    // A start-of-frame sample always lands in slot 0.
    assign slot_s     = in_sof ? '0 : wr_idx_r;
    assign complete_s = accept_s && (slot_s == LAST_IDX);
    assign pub_ok_s   = !frame_valid_r || frame_ready;

    // Next-state, index and publish decisions.
    always_comb begin
        publish_s        = 1'b0;
        state_nx_s       = state_r;
        wr_idx_nx_s      = wr_idx_r;
        frame_valid_nx_s = frame_valid_r;
        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    wr_idx_nx_s = slot_s + IDX_WID'(1);
                end else begin
                    wr_idx_nx_s = wr_idx_r;
                end
                if (complete_s) begin
                    // Index restarts now; a held window is published from the
                    // fill buffer, which is not written again until then.
                    wr_idx_nx_s = '0;
                    if (pub_ok_s) begin
                        publish_s        = 1'b1;
                        frame_valid_nx_s = 1'b1;
                    end else begin
                        state_nx_s = ST_FULL_WAIT;
                    end
                end else if (frame_valid_r && frame_ready) begin
                    frame_valid_nx_s = 1'b0;
                end else begin
                    frame_valid_nx_s = frame_valid_r;
                end
            end
            ST_FULL_WAIT: begin
                // frame_valid is necessarily set here, so ready means consume.
                if (frame_ready) begin
                    publish_s        = 1'b1;
                    frame_valid_nx_s = 1'b1;
                    state_nx_s       = ST_FILL;
                end else begin
                    publish_s = 1'b0;
                end
            end
            default: begin
                state_nx_s       = ST_FILL;
                wr_idx_nx_s      = '0;
                frame_valid_nx_s = 1'b0;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_FILL;
            wr_idx_r      <= '0;
            frame_valid_r <= 1'b0;
            frame_cnt_r   <= '0;
            sof_err_r     <= 1'b0;
            in_ready_r    <= 1'b1;
        end else begin
            state_r       <= state_nx_s;
            wr_idx_r      <= wr_idx_nx_s;
            frame_valid_r <= frame_valid_nx_s;
            in_ready_r    <= (state_nx_s == ST_FILL);
            sof_err_r     <= accept_s && in_sof && (wr_idx_r != '0);
            if (publish_s) begin
                frame_cnt_r <= frame_cnt_r + CNT_WID'(1);
            end
        end
    end

    window_bank #(
        .NUM_INPUTS (NUM_INPUTS),
        .WID        (WID),
        .IDX_WID    (IDX_WID)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (accept_s),
        .wr_slot    (slot_s),
        .wr_data    (in_data),
        .pub_en     (publish_s),
        .frame_data (frame_data)
    );

    assign in_ready    = in_ready_r;
    assign frame_valid = frame_valid_r;
    assign frame_cnt   = frame_cnt_r;
    assign sof_err     = sof_err_r;

endmodule

// File: tb/tb_mean_window_loader.sv
// Directed + randomized bench for mean_window_loader against a queue-based
// window model (NUM_INPUTS=128, WID=16, CNT_WID=4 so the counter wrap is reachable).
module tb_mean_window_loader;

    localparam int N  = 128;
    localparam int W  = 16;
    localparam int CW = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_sof;
    logic             frame_valid;
    logic             frame_ready;
    logic [N*W-1:0]   frame_data;
    logic [CW-1:0]    frame_cnt;
    logic             sof_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] m_fillq [$];
    logic [W-1:0] m_out [N];
    bit           m_pending;
    bit           m_fv;
    int           m_cnt;
    bit           m_sof;

    mean_window_loader #(.NUM_INPUTS(N), .WID(W), .CNT_WID(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_cnt   (frame_cnt),
        .sof_err     (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] exp_bus();
        logic [N*W-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) b[i*W +: W] = m_out[i];
        return b;
    endfunction

    task automatic check_all();
        logic [N*W-1:0] eb;
        eb = exp_bus();
        chk("in_ready", 64'(in_ready), 64'(!m_pending));
        chk("frame_valid", 64'(frame_valid), 64'(m_fv));
        chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
        chk("sof_err", 64'(sof_err), 64'(m_sof));
        checks++;
        assert (frame_data === eb) else begin
            failures++;
            $error("FAIL frame_data observed_slot0=%0h expected_slot0=%0h observed_slot127=%0h expected_slot127=%0h",
                   frame_data[0 +: W], eb[0 +: W], frame_data[(N-1)*W +: W], eb[(N-1)*W +: W]);
        end
    endtask

    task automatic model_reset();
        m_fillq.delete();
        for (int i = 0; i < N; i++) m_out[i] = '0;
        m_pending = 1'b0;
        m_fv      = 1'b0;
        m_cnt     = 0;
        m_sof     = 1'b0;
    endtask

    task automatic model_publish();
        for (int i = 0; i < N; i++) m_out[i] = m_fillq[i];
        m_fillq.delete();
        m_fv  = 1'b1;
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    // One rising edge of the window rules, in terms of whole windows.
    task automatic model_edge(input bit v, input bit s, input logic [W-1:0] d, input bit fr, output bit acc);
        bit cons;
        cons  = m_fv && fr;
        acc   = v && !m_pending;
        m_sof = 1'b0;
        if (m_pending) begin
            if (fr) begin
                model_publish();
                m_pending = 1'b0;
            end
        end else begin
            if (acc) begin
                if (s) begin
                    if (m_fillq.size() != 0) m_sof = 1'b1;
                    m_fillq.delete();
                end
                m_fillq.push_back(d);
            end
            if (m_fillq.size() == N) begin
                if (!m_fv || fr) model_publish();
                else m_pending = 1'b1;
            end else if (cons) begin
                m_fv = 1'b0;
            end
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit fr, output bit acc);
        in_valid    = v;
        in_sof      = s;
        in_data     = d;
        frame_ready = fr;
        @(posedge clk);
        model_edge(v, s, d, fr, acc);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_sof_err", 64'(sof_err), 64'd0);
        chk("rst_frame_data_zero", 64'(frame_data == '0), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        bit acc;
        int sent;
        rst = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_data = '0;
        frame_ready = 1'b0;
        model_reset();
        #12;
        do_reset();

        // Contiguous window 0..127 with frame_ready high
        for (int i = 0; i < N; i++) begin
            step(1'b1, 1'b0, 16'(i), 1'b1, acc);
            if (i < N - 1) chk("t1_no_valid_early", 64'(frame_valid), 64'd0);
        end
        chk("t1_valid", 64'(frame_valid), 64'd1);
        chk("t1_cnt", 64'(frame_cnt), 64'd1);
        chk("t1_slot0", 64'(frame_data[0 +: W]), 64'd0);
        chk("t1_slot127", 64'(frame_data[127*W +: W]), 64'd127);
        chk("t1_ready", 64'(in_ready), 64'd1);

        // Back-pressure: both buffers fill, then one consume
        do_reset();
        sent = 0;
        for (int c = 0; c < 400 && sent < 2 * N; c++) begin
            step(1'b1, 1'b0, 16'(sent), 1'b0, acc);
            if (acc) sent++;
        end
        chk("t2_sent", 64'(sent), 64'd256);
        chk("t2_stall", 64'(in_ready), 64'd0);
        chk("t2_held_slot0", 64'(frame_data[0 +: W]), 64'd0);
        step(1'b0, 1'b0, 16'd0, 1'b1, acc);
        chk("t2_slot0", 64'(frame_data[0 +: W]), 64'd128);
        chk("t2_cnt", 64'(frame_cnt), 64'd2);
        chk("t2_ready_back", 64'(in_ready), 64'd1);
        for (int c = 0; c < 400 && sent < 3 * N; c++) begin
            step(1'b1, 1'b0, 16'(sent), 1'b1, acc);
            if (acc) sent++;
        end
        chk("t2_cnt3", 64'(frame_cnt), 64'd3);
        chk("t2_slot0_third", 64'(frame_data[0 +: W]), 64'd256);

        // SOF resync mid-window
        do_reset();
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 16'($urandom), 1'b1, acc);
        step(1'b1, 1'b1, 16'd1000, 1'b1, acc);
        chk("t3_sof_err", 64'(sof_err), 64'd1);
        for (int i = 1; i < N; i++) step(1'b1, 1'b0, 16'($urandom), 1'b1, acc);
        chk("t3_valid", 64'(frame_valid), 64'd1);
        chk("t3_slot0", 64'(frame_data[0 +: W]), 64'd1000);

        // Reset with a window pending and a partial fill
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 16'($urandom), 1'b0, acc);
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 16'(500 + i), 1'b1, acc);
        chk("t4_cnt", 64'(frame_cnt), 64'd1);
        chk("t4_slot0", 64'(frame_data[0 +: W]), 64'd500);

        // Alternating in_valid gaps
        do_reset();
        sent = 0;
        for (int c = 0; c < 2 * N + 4 && sent < N; c++) begin
            step((c % 2) == 0, 1'b0, 16'(sent), 1'b1, acc);
            if (acc) sent++;
        end
        chk("t5_valid", 64'(frame_valid), 64'd1);
        chk("t5_slot64", 64'(frame_data[64*W +: W]), 64'd64);
        chk("t5_slot127", 64'(frame_data[127*W +: W]), 64'd127);

        // Frame counter wrap with CNT_WID=4
        do_reset();
        for (int w = 0; w < 17; w++) begin
            for (int i = 0; i < N; i++) step(1'b1, 1'b0, 16'($urandom), 1'b1, acc);
            if (w == 14) chk("t6_cnt15", 64'(frame_cnt), 64'd15);
            if (w == 15) chk("t6_wrap0", 64'(frame_cnt), 64'd0);
        end
        chk("t6_after_wrap", 64'(frame_cnt), 64'd1);

        // Randomized traffic with occasional resyncs
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, 16'($urandom),
                 $urandom_range(0, 2) == 0, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
